// File: rtl/slice_cfg_loader.sv
// -----------------------------------------------------------------------------
// slice_cfg_loader
//
// Configuration sequencer for the fracturable-LUT logic slice. Parallel
// bitstream words arrive over a valid/ready handshake and are serialized
// LSB-first into the slice configuration scan chain (per-LUT config words
// followed by the carry-chain enable bit). A bit counter makes the chain
// receive exactly CHAIN_LEN bits; surplus bits of the final word are dropped.
// The user register enable is held off until the chain is fully loaded.
//
// Ports
//   cclk      configuration clock (only clock)
//   rst       asynchronous active-high reset
//   start     one-cycle pulse that begins a load (honoured in IDLE/DONE only)
//   in_data   bitstream word, LSB shifted first
//   in_valid  in_data valid
//   in_ready  loader accepts a word this cycle
//   cfg_bit   serial data to the config chain (0 whenever cen=0)
//   cen       config-chain shift enable
//   user_ce   requested user register enable
//   reg_ce    user_ce gated by done (combinational)
//   busy      load in progress (LOAD or SHIFT)
//   done      chain fully loaded; sticky until the next start or rst
//   bit_cnt   number of chain bits shifted so far in this load
// -----------------------------------------------------------------------------
module slice_cfg_loader #(
  parameter int S_XX_BASE = 4,
  parameter int NUM_LUTS  = 4,
  parameter int CFG_SIZE  = 2**S_XX_BASE + 1,
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = NUM_LUTS*2*CFG_SIZE + 1
) (
  input  logic                           cclk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [WORD_W-1:0]              in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           cfg_bit,
  output logic                           cen,
  input  logic                           user_ce,
  output logic                           reg_ce,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt
);

  localparam int CNT_W = $clog2(CHAIN_LEN+1);
  localparam int WC_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] BIT_FULL  = CNT_W'(CHAIN_LEN);
  localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bit counter increment that can never run past the chain length, so a
  // stray extra shift cycle could not wrap the count back to zero.
  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    r = (c >= BIT_FULL) ? BIT_FULL : c + CNT_W'(1);
    return r;
  endfunction

  // Chain data presented for the coming cycle: shift register LSB, but forced
  // low whenever the chain is not being clocked.
  function automatic logic chain_bit(input logic shifting, input logic [WORD_W-1:0] sr);
    logic r;
    r = shifting & sr[0];
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WC_W-1:0]   wcnt_q,  wcnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

  logic in_ready_q, in_ready_d;
  logic cen_q,      cen_d;
  logic cfg_bit_q,  cfg_bit_d;
  logic busy_q,     busy_d;
  logic done_q,     done_d;

  logic accept;
  logic chain_last;
  logic shift_last;

  // A word is taken only while waiting in LOAD, where in_ready is high.
  assign accept     = (state_q == ST_LOAD) && in_valid;
  // This shift cycle moves the final chain bit.
  assign chain_last = (bit_cnt_q == BIT_LAST);
  // This shift cycle ends the current word, either because the word is
  // exhausted or because the chain is full and the rest is discarded.
  assign shift_last = (wcnt_q == WORD_LAST) || chain_last;

  // ---- state register ------------------------------------------------------
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      wcnt_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      wcnt_q    <= wcnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // ---- next-state and datapath ---------------------------------------------
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    wcnt_d    = wcnt_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_LOAD;
          bit_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          state_d = ST_SHIFT;
          shreg_d = in_data;
          wcnt_d  = '0;
        end
      end
      ST_SHIFT: begin
        shreg_d   = shreg_q >> 1;
        wcnt_d    = wcnt_q + WC_W'(1);
        bit_cnt_d = cnt_inc_sat(bit_cnt_q);
        if (shift_last) begin
          state_d = chain_last ? ST_DONE : ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---- output decode (next-cycle values, registered below) ------------------
  always_comb begin
    in_ready_d = (state_d == ST_LOAD);
    cen_d      = (state_d == ST_SHIFT);
    cfg_bit_d  = chain_bit(cen_d, shreg_d);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
    done_d     = (state_d == ST_DONE);
  end

  // ---- output registers -----------------------------------------------------
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      in_ready_q <= 1'b0;
      cen_q      <= 1'b0;
      cfg_bit_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      in_ready_q <= in_ready_d;
      cen_q      <= cen_d;
      cfg_bit_q  <= cfg_bit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign cen      = cen_q;
  assign cfg_bit  = cfg_bit_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bit_cnt  = bit_cnt_q;

  // User registers stay frozen until the slice holds a complete configuration.
  assign reg_ce   = user_ce & done_q;

endmodule
